// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris playfield store and its
// colour generator.
package tetris_pkg;

  localparam int DEF_ROWS = 20;
  localparam int DEF_COLS = 10;
  localparam int DEF_CW   = 3;

  typedef logic [DEF_CW-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } clr_state_t;

  // Galois-free Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right:
  // feedback taps sit at bits 0, 2, 3 and 5 of the current value.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  // Feedback bit that enters at bit 15 on each shift.
  function automatic logic lfsr_feedback(input logic [15:0] l);
    return ^(l & LFSR_TAP_MASK);
  endfunction

endpackage

// File: rtl/tetris_color_gen.sv
// Next-piece colour generator. next_color is always in 1..7.
// Build option TETRIS_RAND_COLOR_EN: when defined a free-running LFSR
// picks the colour; otherwise a counter steps 1..7 and wraps.
module tetris_color_gen
  import tetris_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          color_req,
  output logic [CW-1:0] next_color
);

  localparam logic [CW-1:0] COLOR_ONE   = CW'(3'd1);
  localparam logic [CW-1:0] COLOR_SEVEN = CW'(3'd7);

  logic [CW-1:0] color_r;

`ifdef TETRIS_RAND_COLOR_EN
  logic [15:0] lfsr_r;

  // LFSR advances every cycle so the pick depends on request timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_feedback(lfsr_r), lfsr_r[15:1]};
    end
  end

  // Latch a new colour from the LFSR on each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_r <= COLOR_ONE;
    end else if (color_req) begin
      color_r <= CW'(lfsr_r % 16'd7) + COLOR_ONE;
    end else begin
      color_r <= color_r;
    end
  end
`else
  // Step through colours 1..7 on each request, wrapping back to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_r <= COLOR_ONE;
    end else if (color_req) begin
      color_r <= (color_r >= COLOR_SEVEN) ? COLOR_ONE : color_r + COLOR_ONE;
    end else begin
      color_r <= color_r;
    end
  end
`endif

  assign next_color = color_r;

endmodule

// File: rtl/tetris_playfield.sv
// ROWS x COLS playfield of colour codes (0 = empty) with a registered
// read port, an IDLE-only write port and a line-clear engine that scans
// bottom-up, collapses full rows and rescans the dropped row.
// Build option TETRIS_RAND_COLOR_EN selects the LFSR colour generator.
module tetris_playfield
  import tetris_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int CW   = DEF_CW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [CW-1:0]             rd_data,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [CW-1:0]             wr_data,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(ROWS+1)-1:0] lines_cleared,
  input  logic                      color_req,
  output logic [CW-1:0]             next_color
);

  localparam int RW = $clog2(ROWS);
  localparam int CI = $clog2(COLS);
  localparam int LW = $clog2(ROWS+1);

  localparam logic [RW:0]   ROWS_V  = (RW+1)'(ROWS);
  localparam logic [CI:0]   COLS_V  = (CI+1)'(COLS);
  localparam logic [RW-1:0] PTR_TOP = RW'(ROWS-1);
  localparam logic [RW-1:0] PTR_ONE = RW'(1'b1);
  localparam logic [RW-1:0] PTR_ZERO = RW'(1'b0);
  localparam logic [LW-1:0] LINES_ONE = LW'(1'b1);
  localparam logic [LW-1:0] LINES_ZERO = LW'(1'b0);

  logic [COLS-1:0][CW-1:0] grid_r [ROWS];
  logic [CW-1:0]           rd_data_r;

  clr_state_t    state_r, state_n;
  logic [RW-1:0] ptr_r, ptr_n;
  logic [LW-1:0] lines_r, lines_n;
  logic          busy_r, done_r;

  logic          rd_ok_s, wr_ok_s, shift_s, row_full_s;

  assign rd_ok_s = ({1'b0, rd_row} < ROWS_V) && ({1'b0, rd_col} < COLS_V);
  assign wr_ok_s = (state_r == IDLE) && wr_en &&
                   ({1'b0, wr_row} < ROWS_V) && ({1'b0, wr_col} < COLS_V);
  assign shift_s = (state_r == SHIFT);

  // Row under the scan pointer is full when every cell is non-zero.
  always_comb begin
    row_full_s = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      row_full_s = row_full_s & (|grid_r[ptr_r][c]);
    end
  end

  // Registered read port; out-of-range addresses read as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {CW{1'b0}};
    end else if (rd_ok_s) begin
      rd_data_r <= grid_r[rd_row][rd_col];
    end else begin
      rd_data_r <= {CW{1'b0}};
    end
  end

  // Grid storage: collapse rows 0..ptr down by one on SHIFT, else lock writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        grid_r[r] <= '{default: {CW{1'b0}}};
      end
    end else if (shift_s) begin
      grid_r[0] <= '{default: {CW{1'b0}}};
      for (int r = 1; r < ROWS; r++) begin
        if (r <= int'(ptr_r)) begin
          grid_r[r] <= grid_r[r-1];
        end
      end
    end else if (wr_ok_s) begin
      grid_r[wr_row][wr_col] <= wr_data;
    end
  end

  // Line-clear next-state logic.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    lines_n = lines_r;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_n = SCAN;
          ptr_n   = PTR_TOP;
          lines_n = LINES_ZERO;
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (row_full_s) begin
          state_n = SHIFT;
        end else if (ptr_r == PTR_ZERO) begin
          state_n = DONE;
        end else begin
          ptr_n = ptr_r - PTR_ONE;
        end
      end
      SHIFT: begin
        lines_n = lines_r + LINES_ONE;
        state_n = SCAN;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line-clear state, pointer, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= PTR_TOP;
      lines_r <= LINES_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      lines_r <= lines_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
    end
  end

  assign rd_data       = rd_data_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign lines_cleared = lines_r;

  tetris_color_gen #(.CW(CW)) u_color_gen (
    .clk        (clk),
    .rst        (rst),
    .color_req  (color_req),
    .next_color (next_color)
  );

endmodule

// File: doc/tetris_playfield.md
# tetris_playfield

Parametrised Tetris playfield store, the successor to the fixed 10×10 grid. It holds a ROWS×COLS array of colour codes and serves a registered read port for the VGA renderer. It also provides a write port for locking piece cells and a line-clear engine that scans rows, removes full ones and drops everything above. A built-in generator supplies the non-zero colour for the next spawned piece.

## Interface
Parameters:
- ROWS, 20, playfield height; row 0 is the top.
- COLS, 10, playfield width.
- CW, 3, colour code width; code 0 means an empty cell.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rd_row  in  $clog2(ROWS)  read row index.
- rd_col  in  $clog2(COLS)  read column index.
- rd_data  out  CW  registered cell value.
- wr_en  in  1  write strobe for locking a piece cell.
- wr_row / wr_col  in  $clog2(ROWS) / $clog2(COLS)  write address.
- wr_data  in  CW  colour to store.
- clear_start  in  1  one-cycle pulse that starts a line-clear pass.
- busy  out  1  a clear pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- lines_cleared  out  $clog2(ROWS+1)  number of rows removed by the last pass; valid from `done` until the next pass starts.
- color_req  in  1  consume the current next_color.
- next_color  out  CW  colour for the next piece; always in 1..7.

## Operation
- Reset state:
  - all cells 0, FSM IDLE, row pointer ROWS-1.
  - rd_data 0, busy 0, done 0, lines_cleared 0.
  - next_color 1, LFSR 16'hACE1.
- Read: rd_data <= grid[rd_row][rd_col] every cycle, including while busy. An out-of-range address returns 0.
- Write: applied at the edge when wr_en=1 and the FSM is IDLE. Writes are dropped while busy or when the address is out of range.
- A row is full when all COLS cells are non-zero.
- FSM states:
  - IDLE: clear_start=1 → SCAN. The pointer r is set to ROWS-1 and lines_cleared is set to 0.
  - SCAN:
    - row r full → SHIFT.
    - row r not full and r=0 → DONE.
    - row r not full and r>0 → SCAN with r-1.
  - SHIFT: in one cycle, rows 1..r take rows 0..r-1 and row 0 is cleared. lines_cleared increments, then → SCAN with the same r, so the dropped row is rescanned.
  - DONE: done=1 → IDLE.
- busy is 1 in SCAN, SHIFT and DONE.
- Priority: clear_start while busy is ignored. If wr_en and clear_start arrive together in IDLE, the write is applied first and the pass sees the written cell.
- Colour generator:
  - LFSR taps x^16+x^14+x^13+x^11+1; it shifts right every cycle with feedback l[0]^l[2]^l[3]^l[5] into bit 15.
  - On color_req, next_color <= (LFSR % 7) + 1.
  - Without color_req, next_color holds its value.

## Timing
- Read latency: 1 cycle.
- Write visibility: a write is visible on rd_data for a read issued in the following cycle.
- Pass length:
  - busy rises the cycle after clear_start and stays high for ROWS + 2k + 1 cycles, where k is the number of rows cleared.
  - done is asserted in the last of those cycles.
- Reset asserted mid-pass aborts the pass immediately and returns everything to the reset state.
- next_color updates one cycle after a color_req edge. Back-to-back requests give one new value per cycle.

## Configuration
- TETRIS_RAND_COLOR_EN defined: the LFSR generator is compiled in, as described above.
- TETRIS_RAND_COLOR_EN undefined: there is no LFSR. next_color steps 1,2,…,7,1 on each color_req, and the reset value is 1.

## Structure
- Package tetris_pkg holds:
  - default ROWS and COLS;
  - typedef color_t (logic [CW-1:0]);
  - enum clr_state_t {IDLE, SCAN, SHIFT, DONE};
  - LFSR_SEED (16'hACE1) and the tap constants.
- One sub-module, tetris_color_gen, holds the LFSR or counter and the next_color register behind the macro.

## Test plan
- Reset, then read all cells → every rd_data = 0, next_color = 1, busy = 0.
- Write 3'b101 to (19,4), then read (19,4) the next cycle → 5. Write to (20,0) → ignored, no cell changes.
- Fill row 19 entirely with 2, place 3 at (18,0), then pulse clear_start → busy for 23 cycles, done with lines_cleared=1, cell (19,0)=3, row 18 all 0.
- Fill rows 19 and 17, leave row 18 with one hole, pulse clear_start → lines_cleared=2, busy for 25 cycles, the old row 18 ends up at row 19.
- Pulse wr_en during busy, and pulse clear_start again mid-pass → the grid is unaffected and only one done pulse occurs. Assert rst mid-pass → grid all 0, busy 0 immediately.
- Issue 1000 consecutive color_req → next_color never 0 and never above 7. With the macro undefined, the values follow 2,3,…,7,1,2.
